counter_sched: RTL

// - Shares one loadable up-counter between N_REQ requesters; round-robin arbitration.
// - Winner's start value is loaded; counter counts up to all-ones, then the winner gets a done pulse.
// - Sits between the requesting control blocks and the shared counter datapath; owns counter load/enable sequencing.

---
 rtl/counter_sched_pkg.sv | 16 +
 rtl/counter_sched_if.sv | 18 +
 rtl/counter_sched_counter.sv | 26 ++
 rtl/counter_sched.sv | 118 +++++++++++
 4 files changed

// File: rtl/counter_sched_pkg.sv
// Shared types and helpers for the round-robin counter scheduler.
package counter_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Terminal count for a w-bit unsigned counter.
  function automatic int unsigned maxv_f(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/counter_sched_if.sv
// Requester-side bus of the counter scheduler: requests, start values, grant/done pulses, status.
interface counter_sched_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] in_val;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [OW-1:0]          owner;
  logic [WIDTH-1:0]       count;

  modport master (output req, in_val, input gnt, done, busy, owner, count);
  modport slave  (input req, in_val, output gnt, done, busy, owner, count);
endinterface

// File: rtl/counter_sched_counter.sv
// Shared loadable up-counter; clr beats load beats en.
module sched_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load)    q_d = d;
    else if (en) q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/counter_sched.sv
// Round-robin sharing of one loadable up-counter among N_REQ requesters.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            clr,
  counter_sched_if.slave  bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(maxv_f(WIDTH));

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] cnt, start;
  logic             ld, en;
  logic [N_REQ-1:0] gnt_o, done_o;

  // First requester at or after p, wrapping at N_REQ (not assumed a power of two).
  function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r, input logic [OW-1:0] p);
    logic [OW-1:0] sel;
    logic          found;
    int            idx;
    sel   = p;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(p) + k) % N_REQ;
      if (!found && r[idx]) begin
        sel   = OW'(idx);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [OW-1:0] inc_wrap(input logic [OW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    start = '0;
    for (int i = 0; i < N_REQ; i++)
      if (owner_q == OW'(i)) start = bus.in_val[i*WIDTH +: WIDTH];
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    ld      = 1'b0;
    en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          owner_d = rr_pick(bus.req, ptr_q);
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ld      = 1'b1;
        state_d = S_COUNT;
      end
      S_COUNT: begin
        // A dropped request abandons the job; count is left where it stopped.
        if (!bus.req[owner_q]) begin
          state_d = S_IDLE;
          ptr_d   = inc_wrap(owner_q);
        end else if (cnt == MAXV) begin
          state_d = S_DONE;
        end else begin
          en = 1'b1;
        end
      end
      S_DONE: begin
        ptr_d   = inc_wrap(owner_q);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  sched_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .clr  (clr),
    .load (ld),
    .en   (en),
    .d    (start),
    .q    (cnt)
  );

  always_comb begin
    gnt_o  = '0;
    done_o = '0;
    if (state_q == S_LOAD) gnt_o[owner_q]  = 1'b1;
    if (state_q == S_DONE) done_o[owner_q] = 1'b1;
  end

  assign bus.gnt   = gnt_o;
  assign bus.done  = done_o;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.owner = owner_q;
  assign bus.count = cnt;
endmodule
